uart_cmd_decoder: RTL

- Byte-level command parser on the receive side of the UART byte stream; the protocol end that consumes what the host sends through UART_RX and answers through UART_TX.
- Parses 5-byte write frames (sync, addr, data hi, data lo, checksum) into single-cycle register-write strobes for the codec/DSP control registers.
- Returns a one-byte ACK or NAK per completed frame through the transmitter load handshake.

---
 rtl/uart_cmd_decoder.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_cmd_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : uart_cmd_decoder
//  Purpose  : Parses 5-byte write frames (sync, addr, data hi, data lo,
//             checksum) from the UART receive byte stream into single-cycle
//             register-write strobes, and returns one ACK/NAK byte per
//             completed frame through the transmitter load handshake.
//  Ports    : clockIN      - system clock
//             resetIN      - asynchronous reset, active-high
//             rxDataIN     - received byte, valid while rxReadyIN=1
//             rxReadyIN    - one-cycle strobe per received byte
//             txReadyIN    - transmitter can accept a byte
//             txDataOUT    - response byte, stable while txLoadOUT=1
//             txLoadOUT    - one-cycle load strobe to the transmitter
//             regWrOUT     - one-cycle register write strobe
//             regAddrOUT   - register address, held until next write
//             regDataOUT   - register data {hi,lo}, held until next write
//             busyOUT      - high whenever the parser is not hunting
//             errCountOUT  - saturating count of checksum errors + timeouts
//  Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 250_000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter logic [7:0]  ACK_BYTE       = 8'h06,
  parameter logic [7:0]  NAK_BYTE       = 8'h15
) (
  input  logic        clockIN,
  input  logic        resetIN,
  input  logic [7:0]  rxDataIN,
  input  logic        rxReadyIN,
  input  logic        txReadyIN,
  output logic [7:0]  txDataOUT,
  output logic        txLoadOUT,
  output logic        regWrOUT,
  output logic [7:0]  regAddrOUT,
  output logic [15:0] regDataOUT,
  output logic        busyOUT,
  output logic [7:0]  errCountOUT
);

  localparam int c_CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_HUNT = 3'd0,
    S_ADDR = 3'd1,
    S_DHI  = 3'd2,
    S_DLO  = 3'd3,
    S_CHK  = 3'd4,
    S_RESP = 3'd5
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [7:0]      r_addr, r_dhi, r_dlo, r_resp;
  logic [7:0]      w_addr_nxt, w_dhi_nxt, w_dlo_nxt, w_resp_nxt;
  logic [c_CW-1:0] r_cnt, w_cnt_nxt;
  logic            w_err_inc;
  logic            r_tx_load, w_tx_load_nxt;
  logic [7:0]      r_tx_data, w_tx_data_nxt;
  logic            r_reg_wr, w_reg_wr_nxt;
  logic [7:0]      r_reg_addr, w_reg_addr_nxt;
  logic [15:0]     r_reg_data, w_reg_data_nxt;
  logic            r_busy;
  logic [7:0]      r_err_cnt;
  logic [7:0]      w_sum;
  logic            w_in_frame;

  assign w_sum      = r_addr ^ r_dhi ^ r_dlo;
  assign w_in_frame = (r_state == S_ADDR) || (r_state == S_DHI) ||
                      (r_state == S_DLO)  || (r_state == S_CHK);

  always_ff @(posedge clockIN or posedge resetIN) begin
    if (resetIN) begin
      r_state    <= S_HUNT;
      r_addr     <= 8'd0;
      r_dhi      <= 8'd0;
      r_dlo      <= 8'd0;
      r_resp     <= 8'd0;
      r_cnt      <= '0;
      r_tx_load  <= 1'b0;
      r_tx_data  <= 8'd0;
      r_reg_wr   <= 1'b0;
      r_reg_addr <= 8'd0;
      r_reg_data <= 16'd0;
      r_busy     <= 1'b0;
      r_err_cnt  <= 8'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_addr     <= w_addr_nxt;
      r_dhi      <= w_dhi_nxt;
      r_dlo      <= w_dlo_nxt;
      r_resp     <= w_resp_nxt;
      r_cnt      <= w_cnt_nxt;
      r_tx_load  <= w_tx_load_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_reg_wr   <= w_reg_wr_nxt;
      r_reg_addr <= w_reg_addr_nxt;
      r_reg_data <= w_reg_data_nxt;
      // Registered copy of the next state so busy lines up with r_state.
      r_busy     <= (w_state_nxt != S_HUNT);
      if (w_err_inc && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_addr_nxt     = r_addr;
    w_dhi_nxt      = r_dhi;
    w_dlo_nxt      = r_dlo;
    w_resp_nxt     = r_resp;
    w_cnt_nxt      = '0;
    w_err_inc      = 1'b0;
    w_tx_load_nxt  = 1'b0;
    w_tx_data_nxt  = r_tx_data;
    w_reg_wr_nxt   = 1'b0;
    w_reg_addr_nxt = r_reg_addr;
    w_reg_data_nxt = r_reg_data;

    // Inter-byte timeout while a frame is open. An arriving byte always
    // wins over expiry because the counter only advances on idle cycles.
    if (w_in_frame && !rxReadyIN) begin
      if (r_cnt == c_CNT_LAST) begin
        w_state_nxt = S_HUNT;
        w_err_inc   = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt + c_CW'(1);
      end
    end

    case (r_state)
      S_HUNT: begin
        if (rxReadyIN && (rxDataIN == SYNC_BYTE)) begin
          w_state_nxt = S_ADDR;
        end
      end
      S_ADDR: begin
        if (rxReadyIN) begin
          w_addr_nxt  = rxDataIN;
          w_state_nxt = S_DHI;
        end
      end
      S_DHI: begin
        if (rxReadyIN) begin
          w_dhi_nxt   = rxDataIN;
          w_state_nxt = S_DLO;
        end
      end
      S_DLO: begin
        if (rxReadyIN) begin
          w_dlo_nxt   = rxDataIN;
          w_state_nxt = S_CHK;
        end
      end
      S_CHK: begin
        if (rxReadyIN) begin
          w_state_nxt = S_RESP;
          if (rxDataIN == w_sum) begin
            w_reg_wr_nxt   = 1'b1;
            w_reg_addr_nxt = r_addr;
            w_reg_data_nxt = {r_dhi, r_dlo};
            w_resp_nxt     = ACK_BYTE;
          end else begin
            w_err_inc  = 1'b1;
            w_resp_nxt = NAK_BYTE;
          end
          // Load the response alongside the write strobe when the
          // transmitter is already free; RESP then only retires.
          if (txReadyIN) begin
            w_tx_load_nxt = 1'b1;
            w_tx_data_nxt = w_resp_nxt;
          end
        end
      end
      S_RESP: begin
        // Incoming bytes are ignored here; the host waits for the reply.
        if (r_tx_load) begin
          w_state_nxt = S_HUNT;
        end else if (txReadyIN) begin
          w_tx_load_nxt = 1'b1;
          w_tx_data_nxt = r_resp;
        end
      end
      default: begin
        w_state_nxt = S_HUNT;
      end
    endcase
  end

  assign txDataOUT   = r_tx_data;
  assign txLoadOUT   = r_tx_load;
  assign regWrOUT    = r_reg_wr;
  assign regAddrOUT  = r_reg_addr;
  assign regDataOUT  = r_reg_data;
  assign busyOUT     = r_busy;
  assign errCountOUT = r_err_cnt;

endmodule
`default_nettype wire
